// File: rtl/booth_host.sv
// rtl/booth_host.sv - request/response sequencer for the 6-bit signed Booth multiplier
// Drives operands over inbus/start and collects the 12-bit product in two outbus beats.
module booth_host #(
  parameter int START_CYC = 2,
  parameter int GAP_CYC   = 3,
  parameter int TIMEOUT   = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [11:0] product,
  output logic        err,
  output logic [5:0]  inbus,
  output logic        start,
  input  logic [5:0]  outbus,
  input  logic        ready
);

  typedef enum logic [2:0] {IDLE, STRT, GAP, WAITB, HI, RESP} state_t;

  localparam int CW = 16;

  state_t      state_q, state_d;
  logic [5:0]  b_q, b_d;
  logic [5:0]  inbus_q, inbus_d;
  logic        start_q, start_d;
  logic        resp_valid_q, resp_valid_d;
  logic        err_q, err_d;
  logic [11:0] product_q, product_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      b_q          <= '0;
      inbus_q      <= '0;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      product_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      inbus_q      <= inbus_d;
      start_q      <= start_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      product_q    <= product_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    inbus_d      = inbus_q;
    start_d      = start_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    product_d    = product_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = STRT;
          start_d   = 1'b1;
          inbus_d   = a;
          b_d       = b;
          cnt_d     = '0;
          product_d = '0;
          err_d     = 1'b0;
        end
      end
      STRT: begin
        if (cnt_q == CW'(START_CYC - 1)) begin
          cnt_d   = '0;
          start_d = 1'b0;
          if (GAP_CYC == 0) begin
            state_d = WAITB;
            inbus_d = b_q;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = WAITB;
          inbus_d = b_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAITB: begin
        // ready takes priority over the timeout on the final wait cycle
        if (ready) begin
          product_d[5:0] = outbus;
          state_d        = HI;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d        = 1'b1;
          product_d    = '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
        cnt_d        = '0;
        if (ready) begin
          product_d[11:6] = outbus;
        end else begin
          err_d     = 1'b1;
          product_d = '0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          err_d        = 1'b0;
          inbus_d      = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign product    = product_q;
  assign err        = err_q;
  assign inbus      = inbus_q;
  assign start      = start_q;

endmodule

// File: tb/tb_booth_host.sv
// tb/tb_booth_host.sv - directed vector bench for booth_host
module tb_booth_host;

  localparam int M_OK    = 0;
  localparam int M_NORDY = 1;
  localparam int M_PULSE = 2;
  localparam int M_STALE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  a = '0;
  logic [5:0]  b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [11:0] product;
  logic        err;
  logic [5:0]  inbus;
  logic        start;
  logic [5:0]  outbus = '0;
  logic        ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    int          mode;
    logic [11:0] exp_p;
    logic        exp_err;
    int          exp_cyc;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  booth_host dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .product    (product),
    .err        (err),
    .inbus      (inbus),
    .start      (start),
    .outbus     (outbus),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled and inputs driven at negedge; cycle c's inputs are taken at edge c.
  task automatic run_row(input vec_t v, input int idx);
    logic signed [11:0] sa, sb, p;
    logic [11:0] p_hold;
    int c, bus_bad, hold_bad;
    bit got;
    sa = 12'($signed(v.a));
    sb = 12'($signed(v.b));
    p  = sa * sb;
    @(negedge clk);
    check($sformatf("req_ready_idle[%0d]", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    a = v.a;
    b = v.b;
    @(negedge clk);
    req_valid = 1'b0;
    a = ~v.a;
    b = ~v.b;
    c = 1;
    got = 1'b0;
    bus_bad = 0;
    while (!got && c < 300) begin
      ready  = 1'b0;
      outbus = '0;
      if (v.mode == M_STALE && c == 4) begin
        ready  = 1'b1;
        outbus = 6'h2A;
      end
      if (v.mode != M_NORDY && c == 46) begin
        ready  = 1'b1;
        outbus = p[5:0];
      end
      if ((v.mode == M_OK || v.mode == M_STALE) && c == 47) begin
        ready  = 1'b1;
        outbus = p[11:6];
      end
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (start !== (c <= 2)) bus_bad++;
        if (inbus !== ((c <= 5) ? v.a : v.b)) bus_bad++;
        if (req_ready !== 1'b0) bus_bad++;
        @(negedge clk);
        c++;
      end
    end
    ready  = 1'b0;
    outbus = '0;
    check($sformatf("resp_seen[%0d]", idx), 32'(got), 32'd1);
    check($sformatf("resp_cycle[%0d]", idx), 32'(c), 32'(v.exp_cyc));
    check($sformatf("product[%0d]", idx), 32'(product), 32'(v.exp_p));
    check($sformatf("err[%0d]", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("bus_seq_errors[%0d]", idx), 32'(bus_bad), 32'd0);
    p_hold = product;
    hold_bad = 0;
    for (int i = 0; i < v.hold; i++) begin
      req_valid = 1'b1;
      a = 6'h11;
      b = 6'h22;
      if (product !== p_hold || req_ready !== 1'b0 || resp_valid !== 1'b1) hold_bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (v.hold > 0) check($sformatf("hold_stable_errors[%0d]", idx), 32'(hold_bad), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("post_resp_valid[%0d]", idx), 32'(resp_valid), 32'd0);
    check($sformatf("post_req_ready[%0d]", idx), 32'(req_ready), 32'd1);
    check($sformatf("post_inbus[%0d]", idx), 32'(inbus), 32'd0);
  endtask

  initial begin
    int nvalid_bad;
    //           a       b       mode     exp_p    err   cyc  hold
    vecs[0] = '{6'd21,  6'd9,   M_OK,    12'h0BD, 1'b0, 48,  0};
    vecs[1] = '{-6'sd7, 6'd10,  M_OK,    12'hFBA, 1'b0, 48,  0};
    vecs[2] = '{6'd5,   -6'sd8, M_OK,    12'hFD8, 1'b0, 48,  10};
    vecs[3] = '{-6'sd13,-6'sd22,M_OK,    12'h11E, 1'b0, 48,  0};
    vecs[4] = '{6'h20,  6'h20,  M_OK,    12'h400, 1'b0, 48,  0};
    vecs[5] = '{6'h20,  6'd31,  M_OK,    12'hC20, 1'b0, 48,  0};
    vecs[6] = '{6'd1,   6'd1,   M_NORDY, 12'h000, 1'b1, 70,  0};
    vecs[7] = '{6'd2,   6'd3,   M_PULSE, 12'h000, 1'b1, 48,  0};
    vecs[8] = '{6'd3,   -6'sd1, M_STALE, 12'hFFD, 1'b0, 48,  0};

    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_inbus", 32'(inbus), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_row(vecs[i], i);

    // reset dropped mid-WAITB
    @(negedge clk);
    req_valid = 1'b1;
    a = 6'd4;
    b = 6'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("midwait_inbus_b", 32'(inbus), 32'd5);
    rst = 1'b1;
    #1;
    check("rst_mid_start", 32'(start), 32'd0);
    check("rst_mid_inbus", 32'(inbus), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("rst_next_start", 32'(start), 32'd0);
    check("rst_next_req_ready", 32'(req_ready), 32'd1);
    nvalid_bad = 0;
    for (int c = 0; c < 60; c++) begin
      ready  = (c >= 25 && c <= 26);
      outbus = 6'h15;
      if (resp_valid !== 1'b0) nvalid_bad++;
      @(negedge clk);
    end
    ready = 1'b0;
    check("dropped_txn_resp_count", 32'(nvalid_bad), 32'd0);

    run_row(vecs[0], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_host.md
# booth_host

Host-side sequencer for the team's 6-bit signed Booth multiplier. It accepts a pair of 6-bit two's-complement operands over a valid/ready request port and drives the multiplier's `inbus`/`start` protocol. It collects the 12-bit product from the multiplier's 6-bit `outbus` in two beats and returns it on a valid/ready response port. It replaces hand-driven operand sequencing with a synthesizable initiator, with a timeout so a hung multiplier cannot stall the system.

## Interface
- `START_CYC`, default 2: cycles `start` is held high with operand A on `inbus`.
- `GAP_CYC`, default 3: cycles A stays on `inbus` after `start` falls, before B is driven.
- `TIMEOUT`, default 63: maximum cycles to wait for `ready` once B is driven.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: operand pair valid.
- `req_ready` out 1: block can accept a request.
- `a` in 6: signed multiplicand.
- `b` in 6: signed multiplier.
- `resp_valid` out 1: response (product and `err`) valid.
- `resp_ready` in 1: consumer takes the response.
- `product` out 12: signed product; 0 when `err`=1.
- `err` out 1: transaction failed (timeout or protocol error).
- `inbus` out 6: operand bus to the multiplier.
- `start` out 1: start strobe to the multiplier.
- `outbus` in 6: result bus from the multiplier.
- `ready` in 1: multiplier result strobe.

## Operation
- States: IDLE, STRT, GAP, WAITB, HI, RESP.
- Reset (asynchronous, any state):
  - state=IDLE.
  - `inbus`=0, `start`=0, `resp_valid`=0, `product`=0, `err`=0, all counters 0.
  - `req_ready`=1, since it is a combinational decode of state==IDLE.
- IDLE:
  - On `req_valid`&&`req_ready`, register `a` and `b`, then go to STRT.
  - `a`/`b` are ignored at all other times.
- STRT: `start`=1, `inbus`=A for exactly `START_CYC` cycles, then GAP.
- GAP: `start`=0, `inbus`=A for `GAP_CYC` cycles, then WAITB. `GAP_CYC`=0 skips GAP.
- WAITB:
  - `inbus`=B, held until the block leaves the state. The wait counter starts at 0 on entry.
  - `ready`=1: capture `outbus` as `product[5:0]`, go to HI.
  - Counter reaches `TIMEOUT` with no `ready`: `err`=1, `product`=0, go to RESP.
- HI:
  - `ready` must still be 1. Capture `outbus` as `product[11:6]`, go to RESP.
  - `ready`=0 in HI is a protocol error: `err`=1, `product`=0, go to RESP.
- RESP:
  - `resp_valid`=1. `product` and `err` are held stable.
  - On `resp_ready`, go to IDLE and clear `resp_valid`, `err` and `inbus`.
- `ready` seen in STRT or GAP is ignored (stale result from a previous operation).
- Products are passed through unmodified: full 12-bit signed range, -32×-32=+1024 (0x400) through -32×31=-992 (0xC20).
- `rst` mid-transaction drops the operation. No response is produced, and `start` falls within the reset assertion.

## Timing
- Request handshake at edge 0.
- `start`=1 from cycle 1 through cycle `START_CYC`.
- B is first on `inbus` at cycle `START_CYC`+`GAP_CYC`+1, which is cycle 6 with defaults.
- Response latency: if `ready` is first seen at WAITB cycle k, `resp_valid` rises 2 cycles later.
- Back-to-back requests:
  - Earliest next acceptance is the cycle after `resp_valid`&&`resp_ready`.
  - The block never overlaps transactions.
- All outputs are registered except `req_ready`.

## Test plan
- Bench uses a behavioural multiplier model that raises `ready` for 2 cycles, low half then high half, 40 cycles after B appears.
- Basic products:
  - a=21, b=9 -> `product`=0x0BD (189), `err`=0.
  - a=-7, b=10 -> 0xFBA (-70).
  - a=5, b=-8 -> 0xFD8 (-40).
  - a=-13, b=-22 -> 0x11E (286).
  - a=-32, b=-32 -> 0x400.
- Bus sequencing, with defaults:
  - `start` is high exactly in cycles 1-2 after the handshake.
  - `inbus`=A in cycles 1-5 and =B from cycle 6 until HI.
  - `req_ready`=0 throughout.
- Timeout: the model never asserts `ready` -> `resp_valid`=1 with `err`=1 and `product`=0, `TIMEOUT`+1 cycles after entering WAITB.
- Protocol error: `ready` pulses for 1 cycle only -> `err`=1.
- Stale `ready` asserted during GAP -> ignored; the correct product is still returned.
- Backpressure: hold `resp_ready`=0 for 10 cycles -> `product` stable and `req_ready`=0. A second request is accepted only after release.
- Reset mid-WAITB -> next cycle `start`=0, `inbus`=0, `req_ready`=1, and no `resp_valid` ever issues for the dropped transaction.
